// File: rtl/psp_test_monitor.sv
// Memory-mapped test-status / watchdog device: LEDs, pass/fail reporting,
// cycle counter and kickable watchdog in a 16-byte bus window.
module psp_test_monitor #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'hFFFF_0000,
  parameter int                    LED_WIDTH      = 4,
  parameter int                    CNT_WIDTH      = 32,
  parameter int                    TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  hit,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [LED_WIDTH-1:0]  led,
  output logic                  done,
  output logic                  pass,
  output logic [DATA_WIDTH-2:0] fail_code,
  output logic                  timeout
);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cycle_cnt, wd_cnt, kick_cnt;
  logic [DATA_WIDTH-1:0]  rdata_mux;
  logic                   accept, wr_tohost, wr_led, wr_kick, finish, expire;
  logic                   unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, mem_addr[1:0]};

  assign hit       = (mem_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign accept    = mem_req && hit && !mem_ready;
  assign wr_tohost = accept && mem_we && (mem_addr[3:2] == 2'd0);
  assign wr_led    = accept && mem_we && (mem_addr[3:2] == 2'd1);
  assign wr_kick   = accept && mem_we && (mem_addr[3:2] == 2'd3);
  assign finish    = wr_tohost && mem_wdata[0];
  assign expire    = (wd_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  // A finishing TOHOST write outranks expiry; a kick in the expiry cycle cancels it.
  always_comb begin
    state_nxt = state;
    if (state == S_RUN) begin
      if (finish)
        state_nxt = (mem_wdata == DATA_WIDTH'(1)) ? S_PASS : S_FAIL;
      else if (expire && !wr_kick)
        state_nxt = S_TIMEOUT;
    end
  end

  always_comb begin
    done    = (state != S_RUN);
    pass    = (state == S_PASS);
    timeout = (state == S_TIMEOUT);
  end

  always_comb begin
    rdata_mux = '0;
    case (mem_addr[3:2])
      2'd1:    rdata_mux = DATA_WIDTH'(led);
      2'd2:    rdata_mux = DATA_WIDTH'(cycle_cnt);
      2'd3:    rdata_mux = DATA_WIDTH'(kick_cnt);
      default: rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      led       <= '0;
      fail_code <= '0;
      cycle_cnt <= '0;
      wd_cnt    <= '0;
      kick_cnt  <= '0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !mem_we) ? rdata_mux : '0;
      if (wr_led)
        led <= mem_wdata[LED_WIDTH-1:0];
      if (state == S_RUN && finish && mem_wdata != DATA_WIDTH'(1))
        fail_code <= mem_wdata[DATA_WIDTH-1:1];
      if (state == S_RUN && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (state == S_RUN)
        wd_cnt <= wr_kick ? '0 : wd_cnt + 1'b1;
      if (wr_kick && kick_cnt != '1)
        kick_cnt <= kick_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_psp_test_monitor.sv
// Directed self-checking bench for psp_test_monitor (TIMEOUT_CYCLES = 50).
module tb_psp_test_monitor;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_HOST = BASE + 32'h0;
  localparam logic [31:0] A_LED  = BASE + 32'h4;
  localparam logic [31:0] A_CYC  = BASE + 32'h8;
  localparam logic [31:0] A_KICK = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        hit, mem_ready, done, pass, timeout;
  logic [31:0] mem_rdata;
  logic [3:0]  led;
  logic [30:0] fail_code;

  int total = 0;
  int bad = 0;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  psp_test_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE),
    .LED_WIDTH(4), .CNT_WIDTH(32), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .hit(hit),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .led(led),
    .done(done), .pass(pass), .fail_code(fail_code), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  // Reset released on a negedge; the following posedge closes cycle 0.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One transaction; ready/rdata captured just after the accept edge.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
    @(posedge clk);
    #1;
    bus_ready = mem_ready;
    bus_rdata = mem_rdata;
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({led, mem_ready, mem_rdata, done, pass, timeout, fail_code} !== '0) begin
      bad++;
      $display("FAIL reset_values actual led=%h rdy=%b rd=%h d=%b p=%b t=%b fc=%h required all zero",
               led, mem_ready, mem_rdata, done, pass, timeout, fail_code);
    end
  endtask

  task automatic test_led();
    bus(1'b1, A_LED, 32'h0000_000A);
    total++;
    if (bus_ready !== 1'b1 || led !== 4'hA) begin
      bad++; $display("FAIL led_write actual rdy=%b led=%h required rdy=1 led=a", bus_ready, led);
    end
    @(posedge clk); #1;
    total++;
    if (mem_ready !== 1'b0) begin
      bad++; $display("FAIL ready_width actual=%b required=0", mem_ready);
    end
    bus(1'b0, A_LED, 32'h0);
    total++;
    if (bus_ready !== 1'b1 || bus_rdata !== 32'h0000_000A) begin
      bad++; $display("FAIL led_read actual rdy=%b rd=%h required rdy=1 rd=0000000a", bus_ready, bus_rdata);
    end
    bus(1'b0, A_HOST, 32'h0);
    total++;
    if (bus_rdata !== 32'h0) begin
      bad++; $display("FAIL tohost_read actual=%h required=00000000", bus_rdata);
    end
  endtask

  task automatic test_pass();
    do_reset();
    repeat (18) @(posedge clk);
    bus(1'b1, A_HOST, 32'h1);
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0) begin
      bad++; $display("FAIL pass_state actual d=%b p=%b t=%b required d=1 p=1 t=0", done, pass, timeout);
    end
    bus(1'b1, A_HOST, 32'h7);
    total++;
    if (pass !== 1'b1 || fail_code !== 31'h0 || bus_ready !== 1'b1) begin
      bad++; $display("FAIL pass_sticky actual p=%b fc=%h rdy=%b required p=1 fc=0 rdy=1", pass, fail_code, bus_ready);
    end
    repeat (60) @(posedge clk);
    #1;
    total++;
    if (timeout !== 1'b0 || pass !== 1'b1) begin
      bad++; $display("FAIL pass_no_timeout actual t=%b p=%b required t=0 p=1", timeout, pass);
    end
  endtask

  task automatic test_fail();
    do_reset();
    bus(1'b1, A_HOST, 32'h0000_002A);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL even_tohost actual done=%b required=0", done);
    end
    bus(1'b1, A_HOST, 32'h0000_002B);
    total++;
    if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 31'h15) begin
      bad++; $display("FAIL fail_state actual d=%b p=%b fc=%h required d=1 p=0 fc=15", done, pass, fail_code);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] first;
    do_reset();
    repeat (49) @(posedge clk);
    #1;
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_early actual=%b required=0", timeout);
    end
    @(posedge clk); #1;
    total++;
    if (timeout !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL timeout_at_50 actual t=%b d=%b required t=1 d=1", timeout, done);
    end
    bus(1'b0, A_CYC, 32'h0);
    first = bus_rdata;
    repeat (7) @(posedge clk);
    bus(1'b0, A_CYC, 32'h0);
    total++;
    if (first !== 32'd50 || bus_rdata !== 32'd50) begin
      bad++; $display("FAIL cycle_frozen actual first=%0d second=%0d required 50 50", first, bus_rdata);
    end
  endtask

  task automatic test_kick();
    do_reset();
    for (int unsigned i = 0; i < 5; i++) begin
      repeat (38) @(posedge clk);
      bus(1'b1, A_KICK, 32'h0);
    end
    bus(1'b0, A_KICK, 32'h0);
    total++;
    if (timeout !== 1'b0 || done !== 1'b0 || bus_rdata !== 32'd5) begin
      bad++; $display("FAIL kick_periodic actual t=%b d=%b kicks=%0d required t=0 d=0 kicks=5", timeout, done, bus_rdata);
    end
  endtask

  task automatic test_kick_expiry();
    do_reset();
    repeat (49) @(posedge clk);
    bus(1'b1, A_KICK, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (timeout !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL kick_at_expiry actual t=%b d=%b required t=0 d=0", timeout, done);
    end
  endtask

  task automatic test_out_of_window();
    logic seen;
    seen = 1'b0;
    do_reset();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1000_0004;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem_ready !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || hit !== 1'b0) begin
      bad++; $display("FAIL out_of_window actual ready_seen=%b hit=%b required 0 0", seen, hit);
    end
    @(negedge clk);
    mem_req = 1'b0;
  endtask

  task automatic test_reset_mid_txn();
    bus(1'b1, A_LED, 32'h5);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = A_LED; mem_wdata = 32'hC;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (led !== 4'h0 || mem_ready !== 1'b0) begin
      bad++; $display("FAIL reset_mid_txn actual led=%h rdy=%b required led=0 rdy=0", led, mem_ready);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_led();
    test_pass();
    test_fail();
    test_timeout();
    test_kick();
    test_kick_expiry();
    test_out_of_window();
    test_reset_mid_txn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
